// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to instruction memory
// (one request outstanding at a time), buffers fetched words in a
// DEPTH-entry FIFO, and presents them to the decoder with a valid/ready
// handshake. A redirect flushes the queue and restarts fetching at the
// target. A fetch still in flight when the redirect arrives is allowed to
// complete, and its data is thrown away.
//
// Build option: define IFQ_BYPASS_EN to present an acked word to the
// decoder in its ack cycle when the queue is empty. Without it, a fetched
// word becomes visible one cycle after its ack.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      pending_pc;
    logic             drop_pending;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    logic empty;
    logic full;
    logic accept;
    logic take_word;
    logic bypass;
    logic pop_fifo;
    logic push_fifo;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    // A pop in a redirect cycle is ignored: the queue is flushed instead.
    assign accept = inst_ready & ~redirect_valid;

    // An acked word is kept only if no flush is in progress or arriving now.
    // rst_n gating keeps an ack seen during reset from reaching the outputs.
    assign take_word = rst_n & imem_ack & ~drop_pending & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
    assign bypass = take_word & empty;
`else
    assign bypass = 1'b0;
`endif

    assign pop_fifo  = ~empty & accept;
    // A bypassed word taken by the decoder in its ack cycle is never stored.
    assign push_fifo = take_word & ~(bypass & accept);

    // Request while there is room, or room appears this cycle, or while an
    // abandoned fetch must still be drained. Once raised, the request stays
    // up: count can only reach full through this request's own ack.
    assign imem_req  = rst_n & (~full | pop_fifo | drop_pending);
    assign imem_addr = fetch_pc;

    assign inst_valid = ~empty | bypass;

    // Head of queue, or the bypassed word, or zero when nothing is valid.
    always_comb begin
        inst_out = '0;
        inst_pc  = '0;
        if (!empty) begin
            inst_out = data_mem[rd_ptr];
            inst_pc  = pc_mem[rd_ptr];
        end else if (bypass) begin
            inst_out = imem_rdata;
            inst_pc  = fetch_pc;
        end
    end

    // Control state: fetch address, redirect/drop tracking, FIFO occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            pending_pc   <= '0;
            drop_pending <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (imem_req && !imem_ack) begin
                // Fetch in flight: let it finish, then jump to the newest target.
                drop_pending <= 1'b1;
                pending_pc   <= redirect_pc;
            end else begin
                drop_pending <= 1'b0;
                fetch_pc     <= redirect_pc;
            end
        end else begin
            if (push_fifo) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_fifo, pop_fifo})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop_pending && imem_ack) begin
                fetch_pc     <= pending_pc;
                drop_pending <= 1'b0;
            end else if (take_word) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // Queue storage: data words and their addresses, written at the tail.
    always_ff @(posedge clk) begin
        if (push_fifo) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a cycle-level instruction memory model with a
// programmable ack delay, a scoreboard of expected {pc, word} entries filled
// as acks are driven and drained as the decoder accepts instructions, and
// a second instance with RESET_PC = 32'hFFFF_FFF8 for address wrap.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_out;
    logic [31:0] w_pc;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;

    inst_fetch_queue u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata),
        .inst_valid     (w_valid),
        .inst_ready     (w_ready),
        .inst_out       (w_out),
        .inst_pc        (w_pc),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    // Memory / reference model state
    logic [31:0] exp_q [$];
    logic [31:0] exp_fetch;
    logic        drop_exp;
    int          wait_cnt;
    int          mem_delay;
    logic [31:0] held_addr;
    int          n_acks;
    int          n_pops;
    int          w_wait;
    int          w_n;
    logic [31:0] w_pcs  [3];
    logic [31:0] w_outs [3];

    // Last mid-cycle sample of the main instance
    logic        smp_req, smp_ack, smp_valid, smp_ready, smp_redir;
    logic [31:0] smp_addr, smp_pc, smp_out, smp_rpc;
    logic        w_s_req, w_s_ack;
    logic [31:0] w_s_addr;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc ^ 32'h2002_0005;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, update models, then drive
    // the next cycle's inputs just after the rising edge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        smp_req   = imem_req;
        smp_ack   = imem_ack;
        smp_addr  = imem_addr;
        smp_valid = inst_valid;
        smp_ready = inst_ready;
        smp_pc    = inst_pc;
        smp_out   = inst_out;
        smp_redir = redirect_valid;
        smp_rpc   = redirect_pc;

        if (wait_cnt > 0) begin
            chk("req_hold", 32'(smp_req), 32'd1);
            chk("addr_hold", smp_addr, held_addr);
        end else if (smp_req) begin
            held_addr = smp_addr;
        end

        if (smp_ack) begin
            n_acks++;
            if (drop_exp || smp_redir) begin
                drop_exp = 1'b0;
            end else begin
                chk("fetch_addr", smp_addr, exp_fetch);
                exp_q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
        end

        if (smp_valid && smp_ready && !smp_redir) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", smp_pc, e);
                chk("inst_out", smp_out, word_of(e));
            end
        end

        if (smp_redir) begin
            exp_q.delete();
            exp_fetch = smp_rpc;
            drop_exp  = smp_req && !smp_ack;
        end

        if (smp_ack) wait_cnt = 0;
        else if (smp_req) wait_cnt++;

        w_s_req  = w_req;
        w_s_ack  = w_ack;
        w_s_addr = w_addr;
        if (w_valid && w_n < 3) begin
            w_pcs[w_n]  = w_pc;
            w_outs[w_n] = w_out;
            w_n++;
        end
        if (w_s_ack) w_wait = 0;
        else if (w_s_req) w_wait++;

        @(posedge clk);
        #1;
        imem_ack       = smp_req && !smp_ack && (wait_cnt >= mem_delay);
        imem_rdata     = imem_ack ? word_of(smp_addr) : 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        w_ack          = w_s_req && !w_s_ack && (w_wait >= 1);
        w_rdata        = w_ack ? word_of(w_s_addr) : 32'hDEAD_BEEF;
    endtask

    // Reset with a spurious ack held high throughout; checks reset outputs.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h1234_5678;
        redirect_valid = 1'b0;
        w_ack          = 1'b1;
        w_rdata        = 32'h1234_5678;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_out", inst_out, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        w_ack      = 1'b0;
        w_rdata    = 32'hDEAD_BEEF;
        wait_cnt   = 0;
        drop_exp   = 1'b0;
        exp_fetch  = 32'h0;
        exp_q.delete();
        n_acks     = 0;
        w_wait     = 0;
        w_n        = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n            = 1'b0;
        imem_ack         = 1'b0;
        imem_rdata       = 32'hDEAD_BEEF;
        inst_ready       = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        w_ack            = 1'b0;
        w_rdata          = 32'hDEAD_BEEF;
        w_ready          = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;
        mem_delay        = 1;
        n_pops           = 0;
        held_addr        = 32'h0;

        do_reset();

        // First cycle out of reset: request at RESET_PC, ack during reset ignored
        tick();
        chk("req_after_reset", 32'(smp_req), 32'd1);
        chk("addr_after_reset", smp_addr, 32'h0);
        chk("valid_after_reset", 32'(smp_valid), 32'd0);

        // Ack cycle of the first word (0x2002_0005) into an empty queue
        tick();
`ifdef IFQ_BYPASS_EN
        chk("ack_cycle_valid", 32'(smp_valid), 32'd1);
`else
        chk("ack_cycle_valid", 32'(smp_valid), 32'd0);
`endif
        tick();
        chk("valid_after_ack", 32'(smp_valid), 32'd1);
        chk("head_pc", smp_pc, 32'h0);
        chk("head_out", smp_out, 32'h2002_0005);

        // Decoder stalled: exactly DEPTH words fetched, then requests stop
        repeat (17) tick();
        chk("acks_when_stalled", 32'(n_acks), 32'd4);
        chk("req_when_full", 32'(smp_req), 32'd0);
        chk("head_pc_held", smp_pc, 32'h0);
        chk("head_out_held", smp_out, 32'h2002_0005);

        // Release the decoder with a slow memory: 0x0..0xC drain, 0x10 requested
        inst_ready = 1'b1;
        mem_delay  = 7;
        p0 = n_pops;
        repeat (4) tick();
        chk("drained_four", 32'(n_pops - p0), 32'd4);
        chk("refill_req", 32'(smp_req), 32'd1);
        chk("refill_addr", smp_addr, 32'h10);

        // Redirect to 0x100 while 0x10 is still in flight
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        for (int i = 0; i < 10 && !smp_ack; i++) tick();
        chk("dropped_ack_arrives", 32'(smp_ack), 32'd1);
        mem_delay = 1;
        tick();
        chk("redirect_addr", smp_addr, 32'h100);
        chk("redirect_req", 32'(smp_req), 32'd1);
        p0 = n_pops;
        repeat (10) tick();
        chk("pops_after_redirect", 32'(n_pops - p0 >= 3), 32'd1);

        // Redirect to 0x200 in a cycle that has both an ack and a pop
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && !(imem_ack && inst_valid); i++) tick();
        chk("found_ack_with_valid", 32'(imem_ack && inst_valid), 32'd1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        tick();
        chk("flush_valid", 32'(smp_valid), 32'd0);
        chk("ack_redirect_addr", smp_addr, 32'h200);
        chk("ack_redirect_req", 32'(smp_req), 32'd1);
        p0 = n_pops;
        repeat (10) tick();
        chk("pops_after_ack_redirect", 32'(n_pops - p0 >= 3), 32'd1);

        // Two redirects while one fetch is in flight: the last one wins
        mem_delay = 6;
        for (int i = 0; i < 20 && !(imem_req && !imem_ack); i++) tick();
        chk("found_pending_req", 32'(imem_req && !imem_ack), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        for (int i = 0; i < 12 && !smp_ack; i++) tick();
        chk("double_drop_ack_arrives", 32'(smp_ack), 32'd1);
        mem_delay = 1;
        tick();
        chk("last_redirect_addr", smp_addr, 32'h400);
        p0 = n_pops;
        repeat (10) tick();
        chk("pops_after_double_redirect", 32'(n_pops - p0 >= 3), 32'd1);

        // Reset in the middle of an outstanding request
        mem_delay = 5;
        for (int i = 0; i < 20 && !(imem_req && !imem_ack); i++) tick();
        chk("found_req_before_reset", 32'(imem_req && !imem_ack), 32'd1);
        tick();
        do_reset();
        mem_delay = 1;
        tick();
        chk("req_after_mid_reset", 32'(smp_req), 32'd1);
        chk("addr_after_mid_reset", smp_addr, 32'h0);
        chk("valid_after_mid_reset", 32'(smp_valid), 32'd0);
        p0 = n_pops;
        repeat (12) tick();
        chk("pops_after_mid_reset", 32'(n_pops - p0 >= 3), 32'd1);

        // Wrap instance: FFFF_FFF8, FFFF_FFFC, 0000_0000
        chk("wrap_count", 32'(w_n), 32'd3);
        chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", w_pcs[2], 32'h0000_0000);
        chk("wrap_out0", w_outs[0], word_of(32'hFFFF_FFF8));
        chk("wrap_out2", w_outs[2], 32'h2002_0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the queue entry count (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have imem_req, output, 1, the fetch request (level).
REQ-006 SHALL have imem_addr, output, 32, the fetch address.
REQ-007 SHALL have imem_ack, input, 1, a single-cycle pulse marking the request complete and imem_rdata valid.
REQ-008 SHALL have imem_rdata, input, 32, the fetched instruction word.
REQ-009 SHALL have inst_valid, output, 1, meaning inst_out/inst_pc hold a valid instruction for the decoder.
REQ-010 SHALL have inst_ready, input, 1, meaning the decoder accepts the instruction this cycle.
REQ-011 SHALL have inst_out, output, 32, the instruction word presented to the decoder.
REQ-012 SHALL have inst_pc, output, 32, the address of inst_out.
REQ-013 SHALL have redirect_valid, input, 1, a single-cycle branch/jump/jr redirect.
REQ-014 SHALL have redirect_pc, input, 32, the redirect target address.

Function
REQ-015 SHALL keep at most one memory request outstanding: imem_req=1 and imem_addr held stable from assertion until the imem_ack cycle inclusive.
REQ-016 SHALL assert imem_req whenever (count < DEPTH) or (count == DEPTH and a pop occurs this cycle), or a drop is pending (REQ-021).
REQ-017 SHALL, on a non-dropped imem_ack, push {imem_rdata, fetch_pc} into the FIFO tail and set fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-018 SHALL allow back-to-back fetches: after an ack, imem_req stays high with the new fetch_pc if REQ-016 still holds.
REQ-019 SHALL drive inst_valid = (count != 0) and inst_out/inst_pc from the FIFO head; an inst_valid && inst_ready cycle is a pop.
REQ-020 SHALL hold inst_out/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-021 SHALL, on redirect_valid, clear the FIFO (count <= 0, inst_valid=0 next cycle), discard any same-cycle push, and ignore any same-cycle pop. If imem_req=1 without imem_ack that cycle, it SHALL set drop_pending and store redirect_pc in pending_pc; otherwise fetch_pc <= redirect_pc.
REQ-022 SHALL, while drop_pending, keep the old imem_addr until imem_ack, discard that imem_rdata, then load fetch_pc <= pending_pc and clear drop_pending.
REQ-023 SHALL, on a further redirect while drop_pending, overwrite pending_pc; the last redirect wins.
REQ-024 SHALL, on redirect_valid coinciding with imem_ack, drop that data and set fetch_pc <= redirect_pc directly.
REQ-025 SHALL accept a simultaneous push and pop at any count, including full (count unchanged) and empty (bypass per REQ-030 only).
REQ-026 SHALL use wrapping read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits; count never exceeds DEPTH.

Reset
REQ-027 SHALL, while rst_n=0, force: fetch_pc=RESET_PC, count=0, pointers=0, drop_pending=0, pending_pc=0, inst_valid=0, imem_req=0, imem_addr=RESET_PC, inst_out=0, inst_pc=0.
REQ-028 SHALL raise imem_req in the first clk cycle after rst_n deasserts; an imem_ack arriving during reset SHALL be ignored.
REQ-029 SHALL, on reset asserted mid-request, abandon the request without waiting for ack.

Configuration
REQ-030 SHALL, with IFQ_BYPASS_EN defined, drive inst_valid=1 and inst_out/inst_pc from imem_rdata/fetch_pc in the ack cycle when count==0 and the data is not dropped; if inst_ready=1 the word is not stored. Without IFQ_BYPASS_EN, fetch-to-valid latency SHALL be exactly one cycle after imem_ack.

Verification
REQ-031 SHALL: after reset, memory acks with a 1-cycle delay, ready=1 -> inst_pc sequence 0x0,0x4,0x8 with matching rdata; no word lost or duplicated.
REQ-032 SHALL: ready=0 for 20 cycles with DEPTH=4 -> exactly 4 acks, then imem_req=0; on ready=1, output 0x0..0xC in order and fetching resumes.
REQ-033 SHALL: redirect to 0x100 while a request for 0x10 is pending (ack 3 cycles later) -> 0x10 data discarded, next imem_addr=0x100, first inst_pc=0x100.
REQ-034 SHALL: redirect to 0x200 coinciding with imem_ack and a pop -> no push, count=0, next imem_addr=0x200.
REQ-035 SHALL: RESET_PC=32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 SHALL: with IFQ_BYPASS_EN and an empty queue, ack data 0x2002_0005 -> inst_valid=1 in the same cycle; without the macro -> one cycle later.
